// File: rtl/jk_cmd_sequencer.sv
// rtl/jk_cmd_sequencer.sv - drives J/K of a downstream falling-edge JK flop and checks its returned q
// Each command applies one op cmd_count+1 times and compares q_fb against an internal model bit.
module jk_cmd_sequencer #(
  parameter int CNT_W  = 4,
  parameter int ERRC_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [CNT_W-1:0]  cmd_count,
  output logic              j,
  output logic              k,
  input  logic              q_fb,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ERRC_W-1:0] err_cnt,
  input  logic              err_clr
);

  typedef enum logic {IDLE = 1'b0, DRIVE = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [1:0]         jk_q, jk_d;
  logic [1:0]         op_q, op_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic               exp_q, exp_q_d;
  logic               exp_valid, exp_valid_d;
  logic               done_d;
  logic               err_d;
  logic [ERRC_W-1:0]  err_cnt_d;
  logic               mismatch;

  // Effect of one falling edge of the downstream flop with {j,k} = op.
  function automatic logic apply_op(input logic [1:0] op, input logic q);
    case (op)
      2'b01:   apply_op = 1'b0;
      2'b10:   apply_op = 1'b1;
      2'b11:   apply_op = ~q;
      default: apply_op = q;
    endcase
  endfunction

  assign mismatch = (state_q == DRIVE) && exp_valid && (q_fb != exp_q);

  always_comb begin
    state_d     = state_q;
    jk_d        = jk_q;
    op_d        = op_q;
    rem_d       = rem_q;
    exp_q_d     = exp_q;
    exp_valid_d = exp_valid;
    done_d      = 1'b0;
    err_d       = err;
    err_cnt_d   = err_cnt;

    case (state_q)
      IDLE: begin
        jk_d = 2'b00;
        if (cmd_valid) begin
          state_d = DRIVE;
          jk_d    = cmd_op;
          op_d    = cmd_op;
          rem_d   = cmd_count;
          exp_q_d = apply_op(cmd_op, exp_q);
          if (cmd_op[1] ^ cmd_op[0]) exp_valid_d = 1'b1;
        end
      end
      DRIVE: begin
        if (mismatch) begin
          err_d = 1'b1;
          if (err_cnt != {ERRC_W{1'b1}}) err_cnt_d = err_cnt + ERRC_W'(1);
        end
        if (rem_q != '0) begin
          rem_d   = rem_q - CNT_W'(1);
          exp_q_d = apply_op(op_q, exp_q);
          if (op_q[1] ^ op_q[0]) exp_valid_d = 1'b1;
        end else begin
          jk_d    = 2'b00;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A clear request overrides a coincident mismatch.
    if (err_clr) begin
      err_d     = 1'b0;
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      jk_q      <= 2'b00;
      op_q      <= 2'b00;
      rem_q     <= '0;
      exp_q     <= 1'b0;
      exp_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state_q   <= state_d;
      jk_q      <= jk_d;
      op_q      <= op_d;
      rem_q     <= rem_d;
      exp_q     <= exp_q_d;
      exp_valid <= exp_valid_d;
      done      <= done_d;
      err       <= err_d;
      err_cnt   <= err_cnt_d;
    end
  end

  assign j         = jk_q[1];
  assign k         = jk_q[0];
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == DRIVE);

endmodule
